regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, range 1..4: number of independent read ports.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only.
REQ-005 Parameter TAP_IDX, default 11: index of register exported on tap.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W].
REQ-010 rd_busy  output  NUM_RD  port k addressed register has an outstanding producer.
REQ-011 we0 / wa0 / wd0  input  1 / ADDR_W / DATA_W  write port 0 enable, address, data.
REQ-012 we1 / wa1 / wd1  input  1 / ADDR_W / DATA_W  write port 1 enable, address, data.
REQ-013 alloc_en / alloc_addr  input  1 / ADDR_W  mark register busy (producer issued).
REQ-014 busy_vec  output  2**ADDR_W  registered busy bit per register.
REQ-015 tap  output  DATA_W  stored value of register TAP_IDX.

Function
REQ-016 Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits, all updated only on rising clk.
REQ-017 Register 0: reads always return 0; writes and allocs to address 0 ignored; busy_vec[0] always 0.
REQ-018 Write: weN=1 and waN!=0 -> reg[waN] <= wdN at the edge; latency 1 cycle to stored value.
REQ-019 Write collision: we0 and we1 both 1, wa0==wa1!=0 -> wd1 stored; wd0 discarded.
REQ-020 Different addresses on both ports -> both written in the same cycle.
REQ-021 Read: combinational; rd_data port k = reg[rd_addr k] when no forwarding applies.
REQ-022 BYPASS=1: if a write port hits rd_addr k (nonzero) this cycle, rd_data k = that port's wd; port 1 takes priority over port 0.
REQ-023 BYPASS=0: rd_data never reflects same-cycle writes.
REQ-024 Forwarding suppressed while reset=0 (rd_data = stored value, i.e. 0 after first reset edge).
REQ-025 Busy set: alloc_en=1, alloc_addr!=0 -> busy[alloc_addr] <= 1 at the edge.
REQ-026 Busy clear: any effective write to address a clears busy[a] at the edge.
REQ-027 Alloc and write same address same cycle -> busy stays/becomes 1 (new producer wins); data still written.
REQ-028 rd_busy k = busy[rd_addr k] AND NOT (BYPASS=1 and a write hits rd_addr k this cycle); rd_busy for address 0 always 0.
REQ-029 tap = reg[TAP_IDX] stored value, never forwarded; TAP_IDX=0 gives constant 0.
REQ-030 All read ports independent; any ports may address the same register with identical results.

Reset
REQ-031 reset=0 at a rising edge: all registers <= 0, all busy bits <= 0; tap, busy_vec, rd_busy read 0 from the following cycle.
REQ-032 Reset dominates: writes and allocs presented in a reset cycle are discarded.
REQ-033 Reset mid-operation (busy bits set, writes in flight) -> identical result to power-up reset; no partial state retained.
REQ-034 No initial-block dependence; state undefined until the first reset edge.

Verification
REQ-035 Reset then read all 32 addresses on both ports -> rd_data=0, rd_busy=0, busy_vec=0, tap=0.
REQ-036 we0=1, wa0=11, wd0=0xDEADBEEF, rd_addr0=11 same cycle -> rd_data0=0xDEADBEEF (BYPASS=1), 0 (BYPASS=0); next cycle tap=0xDEADBEEF.
REQ-037 we0/we1=1, wa0=wa1=5, wd0=0x1111, wd1=0x2222 -> forwarded and stored value 0x2222.
REQ-038 we1=1, wa1=0, wd1=0xFFFFFFFF; alloc_addr=0 -> reg0 reads 0, busy_vec[0]=0.
REQ-039 alloc 7, next cycle rd_busy=1; write 7 with alloc 7 same cycle -> busy stays 1; write 7 alone -> rd_busy 0 that cycle (BYPASS=1), busy_vec[7]=0 next.
REQ-040 Regs 3,7 written and busy, then reset=0 with we0=1 wa0=3 -> all regs 0, all busy 0 next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port, dual-write-port register file with a per-register
// busy scoreboard, optional same-cycle write-to-read forwarding and a tap output.
// Register 0 is hard-wired to zero and can never be marked busy.
module regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int TAP_IDX = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_addr,
    output logic [2**ADDR_W-1:0]     busy_vec,
    output logic [DATA_W-1:0]        tap
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic wen0;
    logic wen1;
    logic alloc_ok;

    // Writes and allocs to address 0 are dropped here so nothing downstream sees them
    always_comb begin
        wen0     = we0 && (wa0 != '0);
        wen1     = we1 && (wa1 != '0);
        alloc_ok = alloc_en && (alloc_addr != '0);
    end

    // Next busy state: writes clear, a new alloc wins over a same-cycle write
    always_comb begin
        busy_d = busy_q;
        if (wen0) busy_d[wa0] = 1'b0;
        if (wen1) busy_d[wa1] = 1'b0;
        if (alloc_ok) busy_d[alloc_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy scoreboard register; reset dominates any alloc or write
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Storage update; port 1 is assigned last so it wins an address collision
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wen0) regs_q[wa0] <= wd0;
            if (wen1) regs_q[wa1] <= wd1;
        end
    end

    // Combinational read ports with optional forwarding (port 1 over port 0)
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            logic              b;
            logic              hit0;
            logic              hit1;
            a    = rd_addr[k*ADDR_W +: ADDR_W];
            d    = regs_q[a];
            b    = busy_q[a];
            hit1 = (BYPASS != 0) && wen1 && (wa1 == a);
            hit0 = (BYPASS != 0) && wen0 && (wa0 == a);
            // The producer is landing this cycle, so the consumer need not wait
            if (hit1 || hit0) b = 1'b0;
            // Data forwarding is withheld during reset so reads show stored state
            if (reset) begin
                if (hit1)      d = wd1;
                else if (hit0) d = wd0;
            end
            if (a == '0) begin
                d = '0;
                b = 1'b0;
            end
            rd_data[k*DATA_W +: DATA_W] = d;
            rd_busy[k]                  = b;
        end
    end

    assign busy_vec = busy_q;

    // Tap exports stored state only; index 0 collapses to a constant
    generate
        if (TAP_IDX == 0) begin : g_tap_zero
            assign tap = '0;
        end else begin : g_tap_reg
            localparam logic [ADDR_W-1:0] TAP_A = ADDR_W'(TAP_IDX);
            assign tap = regs_q[TAP_A];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: one forwarding instance and one
// non-forwarding instance share all stimulus.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data_b, rd_data_n;
    logic [NUM_RD-1:0]        rd_busy_b, rd_busy_n;
    logic                     we0, we1, alloc_en;
    logic [ADDR_W-1:0]        wa0, wa1, alloc_addr;
    logic [DATA_W-1:0]        wd0, wd1;
    logic [31:0]              busy_vec_b, busy_vec_n;
    logic [DATA_W-1:0]        tap_b, tap_n;

    int checks = 0;
    int errors = 0;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(1), .TAP_IDX(11)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b), .tap(tap_b)
    );

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BYPASS(0), .TAP_IDX(11)) dut_n (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_n), .tap(tap_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; alloc_en = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; alloc_addr = '0;
    endtask

    task automatic rd(input int a0, input int a1);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rd(0, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;

        // Post-reset: everything reads zero on both ports
        for (int a = 0; a < 32; a++) begin
            rd(a, 31 - a);
            #1;
            chk("rst_rd0", rd_data_b[31:0], 32'h0);
            chk("rst_rd1", rd_data_b[63:32], 32'h0);
            chk("rst_busy", {30'b0, rd_busy_b}, 32'h0);
        end
        chk("rst_busyvec", busy_vec_b, 32'h0);
        chk("rst_tap", tap_b, 32'h0);

        // Forwarding of a single write to the tap register
        we0 = 1; wa0 = 11; wd0 = 32'hDEADBEEF; rd(11, 0);
        #1;
        chk("fwd_b", rd_data_b[31:0], 32'hDEADBEEF);
        chk("fwd_n", rd_data_n[31:0], 32'h0);
        chk("tap_before", tap_b, 32'h0);
        tick();
        idle();
        #1;
        chk("tap_b", tap_b, 32'hDEADBEEF);
        chk("tap_n", tap_n, 32'hDEADBEEF);
        chk("stored_n", rd_data_n[31:0], 32'hDEADBEEF);

        // Collision on address 5: port 1 wins in forwarding and storage
        we0 = 1; wa0 = 5; wd0 = 32'h1111; we1 = 1; wa1 = 5; wd1 = 32'h2222; rd(5, 5);
        #1;
        chk("coll_fwd0", rd_data_b[31:0], 32'h2222);
        chk("coll_fwd1", rd_data_b[63:32], 32'h2222);
        chk("coll_nfwd", rd_data_n[63:32], 32'h0);
        tick();
        idle();
        #1;
        chk("coll_st_b", rd_data_b[63:32], 32'h2222);
        chk("coll_st_n", rd_data_n[31:0], 32'h2222);

        // Two different addresses written together
        we0 = 1; wa0 = 9; wd0 = 32'h99; we1 = 1; wa1 = 10; wd1 = 32'hAA; rd(9, 10);
        #1;
        chk("dual_fwd0", rd_data_b[31:0], 32'h99);
        chk("dual_fwd1", rd_data_b[63:32], 32'hAA);
        tick();
        idle();
        #1;
        chk("dual_st0", rd_data_n[31:0], 32'h99);
        chk("dual_st1", rd_data_n[63:32], 32'hAA);

        // Address 0 is immune to writes and allocs
        we1 = 1; wa1 = 0; wd1 = 32'hFFFFFFFF; alloc_en = 1; alloc_addr = 0; rd(0, 0);
        #1;
        chk("r0_fwd", rd_data_b[63:32], 32'h0);
        tick();
        idle();
        #1;
        chk("r0_rd_b", rd_data_b[31:0], 32'h0);
        chk("r0_rd_n", rd_data_n[63:32], 32'h0);
        chk("r0_busyvec", busy_vec_b, 32'h0);

        // Busy scoreboard on register 7
        alloc_en = 1; alloc_addr = 7; rd(7, 0);
        tick();
        idle();
        #1;
        chk("alloc_rdbusy", {31'b0, rd_busy_b[0]}, 32'h1);
        chk("alloc_vec", busy_vec_b, 32'h80);
        we0 = 1; wa0 = 7; wd0 = 32'h77; alloc_en = 1; alloc_addr = 7;
        #1;
        chk("wa_rdbusy_b", {31'b0, rd_busy_b[0]}, 32'h0);
        chk("wa_rdbusy_n", {31'b0, rd_busy_n[0]}, 32'h1);
        tick();
        idle();
        #1;
        chk("wa_vec", busy_vec_b, 32'h80);
        chk("wa_data", rd_data_n[31:0], 32'h77);
        we0 = 1; wa0 = 7; wd0 = 32'h70;
        #1;
        chk("w_rdbusy_b", {31'b0, rd_busy_b[0]}, 32'h0);
        chk("w_rdbusy_n", {31'b0, rd_busy_n[0]}, 32'h1);
        tick();
        idle();
        #1;
        chk("w_vec", busy_vec_b, 32'h0);
        chk("w_data", rd_data_b[31:0], 32'h70);

        // Mid-operation reset with busy bits set and a write in flight
        we0 = 1; wa0 = 3; wd0 = 32'h33; alloc_en = 1; alloc_addr = 3;
        tick();
        idle();
        alloc_en = 1; alloc_addr = 7;
        tick();
        idle();
        #1;
        chk("pre_rst_vec", busy_vec_b, 32'h88);
        reset = 0; we0 = 1; wa0 = 3; wd0 = 32'h99; alloc_en = 1; alloc_addr = 5; rd(3, 7);
        #1;
        chk("rst_nofwd", rd_data_b[31:0], 32'h33);
        tick();
        reset = 1;
        idle();
        #1;
        chk("mid_vec_b", busy_vec_b, 32'h0);
        chk("mid_vec_n", busy_vec_n, 32'h0);
        chk("mid_tap", tap_b, 32'h0);
        for (int a = 0; a < 32; a++) begin
            rd(a, a);
            #1;
            chk("mid_rd_b", rd_data_b[31:0], 32'h0);
            chk("mid_rd_n", rd_data_n[63:32], 32'h0);
            chk("mid_busy", {30'b0, rd_busy_b}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
